mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and address-decode helper for the
// byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_WID      = 32;
  localparam int IF_LINE_BYTES = 64;
  localparam int IF_DATA_WID   = 8 * IF_LINE_BYTES;

  // IO space is selected by two address bits; 2'b11 means the UART window.
  localparam int         IO_HI  = 17;
  localparam int         IO_LO  = 16;
  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_READ  = 2'd1,
    ST_LS_READ  = 2'd2,
    ST_LS_WRITE = 2'd3
  } state_t;

  function automatic logic is_io_addr(input logic [ADDR_WID-1:0] addr);
    return addr[IO_HI:IO_LO] == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: shares the single 8-bit RAM/IO port between
// the fetch unit (whole cache lines) and the load/store buffer (1/2/4 bytes).
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int IF_BYTES = IF_LINE_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_en,
  input  logic [ADDR_WID-1:0]   if_pc,
  output logic                  if_done,
  output logic [8*IF_BYTES-1:0] if_data,
  input  logic                  lsb_en,
  input  logic                  lsb_wr,
  input  logic [ADDR_WID-1:0]   lsb_addr,
  input  logic [2:0]            lsb_len,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WID-1:0]   mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam int         LINE_WID = 8 * IF_BYTES;
  localparam logic [6:0] IF_N     = 7'(IF_BYTES);

  state_t                state_q, state_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [6:0]            len_q, len_d;
  logic [ADDR_WID-1:0]   base_q, base_d;
  logic [ADDR_WID-1:0]   mem_a_q, mem_a_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           lsb_rdata_q, lsb_rdata_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d;
  logic                  lsb_done_q, lsb_done_d;
  // Bytes are assembled here and only copied to the visible outputs on
  // completion, so an aborted transfer leaves if_data/lsb_rdata untouched.
  logic [LINE_WID-1:0]   buf_q, buf_d;
  logic [LINE_WID-1:0]   if_data_q, if_data_d;

  logic [6:0]            cnt_inc;
  logic [6:0]            cap_idx;
  logic [1:0]            wsel;
  logic                  served_en;
  logic                  lsb_blocked;
  logic [31:0]           ld_mask;

  assign cnt_inc     = cnt_q + 7'd1;
  assign cap_idx     = cnt_q - 7'd1;
  assign wsel        = cnt_inc[1:0];
  assign served_en   = (state_q == ST_IF_READ) ? if_en : lsb_en;
  assign lsb_blocked = lsb_wr && is_io_addr(lsb_addr) && io_buffer_full;

  // Zero-extension mask for the load result, chosen by the latched length.
  always_comb begin
    ld_mask = 32'hFFFF_FFFF;
    case (len_q)
      7'd1:    ld_mask = 32'h0000_00FF;
      7'd2:    ld_mask = 32'h0000_FFFF;
      default: ld_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Next-state logic: arbitration, byte sequencing, abort and completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    mem_a_d     = mem_a_q;
    wdata_d     = wdata_q;
    lsb_rdata_d = lsb_rdata_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The done cycle is never an accept cycle: a requester whose enable
        // is still high while its done pulse is out must not be re-served.
        if (!if_done_q && !lsb_done_q) begin
          if (lsb_en) begin
            if (!lsb_blocked) begin
              base_d  = lsb_addr;
              len_d   = {4'd0, lsb_len};
              wdata_d = lsb_wdata;
              cnt_d   = 7'd0;
              mem_a_d = lsb_addr;
              if (lsb_wr) begin
                state_d    = ST_LS_WRITE;
                mem_wr_d   = 1'b1;
                mem_dout_d = lsb_wdata[7:0];
              end else begin
                state_d = ST_LS_READ;
              end
            end
          end else if (if_en) begin
            base_d  = if_pc;
            len_d   = IF_N;
            cnt_d   = 7'd0;
            mem_a_d = if_pc;
            state_d = ST_IF_READ;
          end
        end
      end

      ST_IF_READ, ST_LS_READ: begin
        if (!served_en) begin
          state_d  = ST_IDLE;
          mem_wr_d = 1'b0;
          mem_a_d  = '0;
          cnt_d    = 7'd0;
        end else begin
          // RAM data lags the address by one cycle, so byte cnt-1 is on
          // mem_din now.
          if (cnt_q != 7'd0) begin
            buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            mem_a_d = '0;
            cnt_d   = 7'd0;
            if (state_q == ST_IF_READ) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_d[31:0] & ld_mask;
            end
          end else begin
            mem_a_d = base_q + {25'd0, cnt_q} + 32'd1;
            cnt_d   = cnt_inc;
          end
        end
      end

      ST_LS_WRITE: begin
        if (!lsb_en) begin
          state_d  = ST_IDLE;
          mem_wr_d = 1'b0;
          mem_a_d  = '0;
          cnt_d    = 7'd0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc < len_q) begin
            mem_a_d    = base_q + {25'd0, cnt_inc};
            mem_dout_d = wdata_q[{wsel, 3'b000} +: 8];
          end else begin
            state_d    = ST_IDLE;
            mem_wr_d   = 1'b0;
            mem_a_d    = '0;
            lsb_done_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register: reset wins over rdy, rdy=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 7'd0;
      len_q       <= 7'd0;
      base_q      <= '0;
      mem_a_q     <= '0;
      wdata_q     <= '0;
      lsb_rdata_q <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      buf_q       <= '0;
      if_data_q   <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      mem_a_q     <= mem_a_d;
      wdata_q     <= wdata_d;
      lsb_rdata_q <= lsb_rdata_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
    end
  end

  // A frozen write cycle must not keep strobing the RAM.
  assign mem_wr    = mem_wr_q & rdy;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array RAM on the memory pins, a
// shadow memory as reference model, expectation queues popped by a monitor.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int NB = IF_LINE_BYTES;

  logic         clk = 1'b0;
  logic         rst, rdy;
  logic         if_en, if_done;
  logic [31:0]  if_pc;
  logic [511:0] if_data;
  logic         lsb_en, lsb_wr, lsb_done;
  logic [31:0]  lsb_addr, lsb_wdata, lsb_rdata;
  logic [2:0]   lsb_len;
  logic [7:0]   mem_din, mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr, io_buffer_full;

  always #5 clk = ~clk;

  mem_ctrl #(.IF_BYTES(NB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // 64 KiB RAM seen by the DUT (address aliased on bits 15:0) and the
  // reference copy updated by the stimulus side when a store is issued.
  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];

  // Synchronous RAM, one cycle read latency; its read register shares the
  // system clock enable so a stall does not skip a byte.
  always @(posedge clk) begin
    if (rdy) mem_din <= ram[mem_a[15:0]];
    if (mem_wr) ram[mem_a[15:0]] = mem_dout;
  end

  typedef struct packed { logic is_load; logic [31:0] rdata; } ls_exp_t;
  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_exp_t;

  logic [511:0] if_q [$];
  ls_exp_t      ls_q [$];
  wr_exp_t      wr_q [$];
  logic [511:0] last_line;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [31:0] pc);
    logic [511:0] r;
    logic [31:0]  a;
    r = '0;
    for (int k = 0; k < NB; k++) begin
      a = pc + 32'(k);
      r[8*k +: 8] = ref_mem[a[15:0]];
    end
    return r;
  endfunction

  function automatic logic [31:0] load_of(input logic [31:0] addr, input int len);
    logic [31:0] r;
    logic [31:0] a;
    r = '0;
    for (int k = 0; k < len; k++) begin
      a = addr + 32'(k);
      r[8*k +: 8] = ref_mem[a[15:0]];
    end
    return r;
  endfunction

  // Monitor: every output event pops the matching expectation.
  always @(negedge clk) begin
    logic [511:0] e_line;
    ls_exp_t      e_ls;
    wr_exp_t      e_wr;
    if (!rst) begin
      if (if_done) begin
        if (if_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL if_done_unexpected: got pulse required none");
        end else begin
          e_line = if_q.pop_front();
          check("if_data", if_data, e_line);
        end
      end
      if (lsb_done) begin
        if (ls_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL lsb_done_unexpected: got pulse required none");
        end else begin
          e_ls = ls_q.pop_front();
          if (e_ls.is_load) check("lsb_rdata", 512'(lsb_rdata), 512'(e_ls.rdata));
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mem_wr_unexpected: got write a=%0h d=%0h required none", mem_a, mem_dout);
        end else begin
          e_wr = wr_q.pop_front();
          check("wr_addr", 512'(mem_a), 512'(e_wr.a));
          check("wr_data", 512'(mem_dout), 512'(e_wr.d));
        end
      end
    end
  end

  // Waits (bounded) for the done pulse, checks the latency in cycles from
  // request raise, then lets the done edge pass with the enable still high.
  task automatic wait_done(input bit is_if, input int exp_lat, input string name);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      seen = is_if ? if_done : lsb_done;
    end
    check(name, 512'(cyc), 512'(exp_lat));
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int exp_lat);
    logic [511:0] e;
    e = line_of(pc);
    if_q.push_back(e);
    last_line = e;
    $display("txn fetch pc=%08h latency_exp=%0d", pc, exp_lat);
    if_pc = pc;
    if_en = 1'b1;
    wait_done(1'b1, exp_lat, "fetch_latency");
    if_en = 1'b0;
    check("idle_after_fetch", 512'({mem_wr, mem_a}), 512'(0));
  endtask

  task automatic do_ls(input bit wr, input logic [31:0] addr, input int len,
                       input logic [31:0] wdata, input int exp_lat);
    logic [31:0] a;
    if (wr) begin
      for (int k = 0; k < len; k++) begin
        a = addr + 32'(k);
        ref_mem[a[15:0]] = wdata[8*k +: 8];
        wr_q.push_back('{a: a, d: wdata[8*k +: 8]});
      end
      ls_q.push_back('{is_load: 1'b0, rdata: 32'd0});
    end else begin
      ls_q.push_back('{is_load: 1'b1, rdata: load_of(addr, len)});
    end
    $display("txn %s addr=%08h len=%0d wdata=%08h latency_exp=%0d",
             wr ? "store" : "load", addr, len, wdata, exp_lat);
    lsb_wr    = wr;
    lsb_addr  = addr;
    lsb_len   = 3'(len);
    lsb_wdata = wdata;
    lsb_en    = 1'b1;
    wait_done(1'b0, exp_lat, wr ? "store_latency" : "load_latency");
    lsb_en = 1'b0;
    check("idle_after_ls", 512'({mem_wr, mem_a}), 512'(0));
  endtask

  initial begin
    logic [7:0]  v;
    int          kind, len, pick;
    logic [31:0] addr, wd;

    for (int i = 0; i < 65536; i++) begin
      v = (i < 16'h4000) ? 8'(i) : 8'($urandom);
      ram[i]     = v;
      ref_mem[i] = v;
    end
    last_line      = '0;
    rst            = 1'b1;
    rdy            = 1'b0;
    if_en          = 1'b0;
    if_pc          = '0;
    lsb_en         = 1'b0;
    lsb_wr         = 1'b0;
    lsb_addr       = '0;
    lsb_len        = 3'd0;
    lsb_wdata      = '0;
    io_buffer_full = 1'b0;

    // Reset with rdy low: reset must still take effect.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_done", 512'(if_done), 512'(0));
    check("rst_lsb_done", 512'(lsb_done), 512'(0));
    check("rst_if_data", if_data, 512'(0));
    check("rst_lsb_rdata", 512'(lsb_rdata), 512'(0));
    check("rst_mem_a", 512'(mem_a), 512'(0));
    check("rst_mem_dout", 512'(mem_dout), 512'(0));
    check("rst_mem_wr", 512'(mem_wr), 512'(0));
    rst = 1'b0;
    rdy = 1'b1;
    @(negedge clk);

    // Full line fetch, RAM byte k = k.
    do_fetch(32'h100, NB + 2);
    check("fetch100_lo", 512'(if_data[31:0]), 512'(32'h03020100));
    check("fetch100_hi", 512'(if_data[511:504]), 512'(8'h3F));

    // Load and fetch raised together: load first, fetch on the next free cycle.
    fork
      do_ls(1'b0, 32'h1002, 4, 32'd0, 6);
      do_fetch(32'h140, 6 + 1 + 1 + NB + 1);
    join
    check("load1002", 512'(lsb_rdata), 512'(32'h05040302));

    // Half-word store.
    do_ls(1'b1, 32'h200, 2, 32'h0000BEEF, 3);

    // IO store held off by a full UART buffer for 5 cycles.
    io_buffer_full = 1'b1;
    fork
      do_ls(1'b1, 32'h30000, 1, 32'h0000005A, 7);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("io_hold", 512'({mem_wr, mem_a}), 512'(0));
        end
        io_buffer_full = 1'b0;
      end
    join

    // Fetch aborted with cnt=20, then an immediate fresh fetch.
    $display("txn fetch pc=%08h aborted_at_cnt=20", 32'h180);
    if_pc = 32'h180;
    if_en = 1'b1;
    repeat (21) @(negedge clk);
    if_en = 1'b0;
    @(negedge clk);
    check("abort_idle", 512'({mem_wr, mem_a}), 512'(0));
    check("abort_if_data_kept", if_data, last_line);
    do_fetch(32'h1C0, NB + 2);

    // Three-cycle stall in the middle of a fetch.
    fork
      do_fetch(32'h240, NB + 2 + 3);
      begin
        repeat (30) @(negedge clk);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_mem_a", 512'(mem_a), 512'(32'h240 + 29));
          check("stall_mem_wr", 512'(mem_wr), 512'(0));
        end
        rdy = 1'b1;
      end
    join

    // Randomized mix over a small region so loads/fetches see earlier stores.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      pick = $urandom_range(0, 2);
      len  = (pick == 0) ? 1 : (pick == 1) ? 2 : 4;
      addr = 32'h4000 + 32'($urandom_range(0, 32'h0FF0));
      wd   = $urandom;
      case (kind)
        0:       do_fetch({addr[31:6], 6'd0}, NB + 2);
        1:       do_ls(1'b0, addr, len, 32'd0, len + 2);
        default: do_ls(1'b1, addr, len, wd, len + 1);
      endcase
    end

    repeat (5) @(negedge clk);
    check("if_q_drained", 512'(if_q.size()), 512'(0));
    check("ls_q_drained", 512'(ls_q.size()), 512'(0));
    check("wr_q_drained", 512'(wr_q.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
